mixcol_engine: RTL and testbench

MIXCOL_ENGINE -- requirements
Module: mixcol_engine

---
 rtl/mixcol_engine.sv | 120 ++++++++++++
 tb/tb_mixcol_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mixcol_engine.sv
// AES MixColumns / InvMixColumns engine with a valid/ready handshake on both sides.
// LANES columns are transformed per CALC cycle; bypass blocks skip straight to DONE.
module mixcol_engine #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         inv,
  input  logic         enable,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_badLanes
      $error("mixcol_engine: LANES must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [2:0]         r_count;
  logic               r_inv;
  logic [3:0][31:0]   r_block;
  logic [3:0][31:0]   w_calcBlock;
  logic               w_accept;
  logic               w_lastGroup;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Coefficients never exceed 0x0E, so four doubling steps cover every product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (k[2'(i)]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] col, input logic inverse);
    logic [3:0][7:0] b;
    logic [3:0][7:0] res;
    logic [0:3][3:0] coef;
    b    = col;
    coef = inverse ? {4'hE, 4'hB, 4'hD, 4'h9} : {4'h2, 4'h3, 4'h1, 4'h1};
    res  = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[2'(3 - r)] ^= gmul(b[2'(3 - c)], coef[2'(c - r)]);
      end
    end
    return res;
  endfunction

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_lastGroup = (r_count == 3'(4 - LANES));

  // Columns are independent, so the group is rewritten in place inside r_block.
  always_comb begin
    logic [1:0] w_colIdx;
    w_calcBlock = r_block;
    w_colIdx    = 2'd0;
    for (int l = 0; l < LANES; l++) begin
      w_colIdx = r_count[1:0] + 2'(l);
      w_calcBlock[2'd3 - w_colIdx] = mixColumn(r_block[2'd3 - w_colIdx], r_inv);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = enable ? CALC : DONE;
      CALC:    if (w_lastGroup) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 3'd0;
      r_inv   <= 1'b0;
      r_block <= '0;
    end else if (w_accept) begin
      r_count <= 3'd0;
      r_inv   <= inv;
      r_block <= in_data;
    end else if (r_state == CALC) begin
      r_count <= r_count + 3'(LANES);
      r_block <= w_calcBlock;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_block;

endmodule

// File: tb/tb_mixcol_engine.sv
// Drives three engines (LANES 1, 2, 4) in lockstep and compares every result
// against a GF(2^8) matrix-product model of MixColumns / InvMixColumns.
module tb_mixcol_engine;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic [127:0] inData;
  logic         inv;
  logic         enable;
  logic [2:0]   outReady;
  logic [2:0]   inReady;
  logic [2:0]   outValid;
  logic [2:0]   busyV;
  logic [127:0] outData [3];

  int passCount;
  int checkCount;
  int lanesOf [3] = '{1, 2, 4};

  mixcol_engine #(.LANES(1)) u_lanes1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[0]), .in_data(inData),
    .inv(inv), .enable(enable), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_data(outData[0]), .busy(busyV[0]));

  mixcol_engine #(.LANES(2)) u_lanes2 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[1]), .in_data(inData),
    .inv(inv), .enable(enable), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_data(outData[1]), .busy(busyV[1]));

  mixcol_engine #(.LANES(4)) u_lanes4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[2]), .in_data(inData),
    .inv(inv), .enable(enable), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_data(outData[2]), .busy(busyV[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Schoolbook product followed by long division by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[3'(i)]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[4'(i)]) p ^= (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] refMix(input logic [127:0] blk, input logic invBit);
    logic [15:0][7:0] src;
    logic [15:0][7:0] dst;
    logic [0:15][7:0] m;
    logic [7:0]       acc;
    src = blk;
    dst = '0;
    if (invBit) m = {8'h0E, 8'h0B, 8'h0D, 8'h09,  8'h09, 8'h0E, 8'h0B, 8'h0D,
                     8'h0D, 8'h09, 8'h0E, 8'h0B,  8'h0B, 8'h0D, 8'h09, 8'h0E};
    else        m = {8'h02, 8'h03, 8'h01, 8'h01,  8'h01, 8'h02, 8'h03, 8'h01,
                     8'h01, 8'h01, 8'h02, 8'h03,  8'h03, 8'h01, 8'h01, 8'h02};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gfMul(src[4'(15 - 4*c - k)], m[4'(4*r + k)]);
        dst[4'(15 - 4*c - r)] = acc;
      end
    end
    return dst;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  // Hands one block to all three engines and follows each until it retires.
  task automatic applyStimulus(input logic [127:0] data, input logic invBit, input logic enBit,
                               input bit stall, output logic [127:0] result);
    logic [127:0] expected;
    bit           seen [3];
    bit           retired [3];
    int           waitCyc;
    expected = enBit ? refMix(data, invBit) : data;
    result   = '0;
    for (int i = 0; i < 3; i++) begin
      seen[2'(i)]    = 1'b0;
      retired[2'(i)] = 1'b0;
    end
    waitCyc = 0;
    while (!(&inReady) && waitCyc < 20) begin
      tick;
      waitCyc++;
    end
    checkOutput("idle_before_accept", 128'(&inReady), 128'd1);
    inData  = data;
    inv     = invBit;
    enable  = enBit;
    inValid = 1'b1;
    tick;
    inValid = 1'b0;
    inData  = {$urandom(), $urandom(), $urandom(), $urandom()};
    inv     = ~invBit;
    enable  = ~enBit;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!retired[2'(i)]) begin
          if (outValid[2'(i)]) begin
            if (!seen[2'(i)]) begin
              seen[2'(i)] = 1'b1;
              checkOutput($sformatf("latency_L%0d", lanesOf[2'(i)]), 128'(cyc),
                          128'(enBit ? (4 / lanesOf[2'(i)] + 1) : 1));
              if (i == 0) result = outData[0];
            end
            checkOutput($sformatf("data_L%0d", lanesOf[2'(i)]), outData[2'(i)], expected);
          end else if (seen[2'(i)]) begin
            retired[2'(i)] = 1'b1;
          end
        end
      end
      if (retired[0] && retired[1] && retired[2]) break;
      for (int i = 0; i < 3; i++) outReady[2'(i)] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick;
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("retired_L%0d", lanesOf[2'(i)]), 128'(retired[2'(i)]), 128'd1);
    outReady = 3'b111;
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] back;
    logic [127:0] rnd;
    logic [127:0] bpExpected;
    int           holdErr [3];
    int           staleSeen;

    passCount  = 0;
    checkCount = 0;
    rst        = 1'b1;
    inValid    = 1'b1;
    inData     = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
    inv        = 1'b0;
    enable     = 1'b1;
    outReady   = 3'b111;
    $display("[TB] reset with in_valid held high");
    tick;
    tick;
    rst     = 1'b0;
    inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_in_ready_L%0d", lanesOf[2'(i)]), 128'(inReady[2'(i)]), 128'd1);
      checkOutput($sformatf("reset_out_valid_L%0d", lanesOf[2'(i)]), 128'(outValid[2'(i)]), 128'd0);
      checkOutput($sformatf("reset_busy_L%0d", lanesOf[2'(i)]), 128'(busyV[2'(i)]), 128'd0);
      checkOutput($sformatf("reset_out_data_L%0d", lanesOf[2'(i)]), outData[2'(i)], 128'd0);
    end

    $display("[TB] directed forward, inverse and bypass vectors");
    applyStimulus(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b1, 1'b0, res);
    checkOutput("fwd_vector", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    applyStimulus(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, 1'b1, 1'b0, res);
    checkOutput("inv_vector", res, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
    applyStimulus(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b0, 1'b0, res);
    checkOutput("bypass_vector", res, 128'h00112233_44556677_8899aabb_ccddeeff);

    $display("[TB] backpressure with in_valid pushing during DONE");
    bpExpected = refMix(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    outReady   = 3'b000;
    inData     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    inv        = 1'b0;
    enable     = 1'b1;
    inValid    = 1'b1;
    tick;
    inValid = 1'b0;
    for (int cyc = 0; cyc < 10 && !(&outValid); cyc++) tick;
    checkOutput("bp_all_valid", 128'(&outValid), 128'd1);
    for (int i = 0; i < 3; i++) holdErr[2'(i)] = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      inValid = 1'b1;
      inData  = {$urandom(), $urandom(), $urandom(), $urandom()};
      enable  = 1'(cyc);
      tick;
      for (int i = 0; i < 3; i++)
        if (outValid[2'(i)] !== 1'b1 || inReady[2'(i)] !== 1'b0 || outData[2'(i)] !== bpExpected)
          holdErr[2'(i)]++;
    end
    inValid = 1'b0;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("bp_hold_L%0d", lanesOf[2'(i)]), 128'(holdErr[2'(i)]), 128'd0);
    outReady = 3'b111;
    tick;
    checkOutput("bp_release_valid", 128'(outValid), 128'd0);
    checkOutput("bp_release_ready", 128'(inReady), 128'b111);
    tick;
    tick;
    checkOutput("bp_nothing_accepted", 128'(busyV), 128'd0);

    $display("[TB] reset in the middle of CALC");
    outReady = 3'b000;
    inData   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    inv      = 1'b0;
    enable   = 1'b1;
    inValid  = 1'b1;
    tick;
    inValid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst      = 1'b0;
    outReady = 3'b111;
    checkOutput("mid_reset_out_valid", 128'(outValid), 128'd0);
    checkOutput("mid_reset_in_ready", 128'(inReady), 128'b111);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("mid_reset_out_data_L%0d", lanesOf[2'(i)]), outData[2'(i)], 128'd0);
    staleSeen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick;
      if (|outValid) staleSeen++;
    end
    checkOutput("mid_reset_no_stale", 128'(staleSeen), 128'd0);

    $display("[TB] forward then inverse round trips");
    for (int n = 0; n < 4; n++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(rnd, 1'b0, 1'b1, 1'b1, res);
      applyStimulus(res, 1'b1, 1'b1, 1'b1, back);
      checkOutput("round_trip", back, rnd);
    end

    $display("[TB] random regression");
    for (int n = 0; n < 25; n++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, res);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
